// File: rtl/buffer_pkg.sv
// Shared types and defaults for the buffer stream reader and its output FIFO.
package buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  localparam int CNT_W      = 3;

  function automatic logic [CNT_W-1:0] credit_limit(input int rd_lat);
    credit_limit = CNT_W'(rd_lat + 1);
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Small synchronous FIFO holding captured read words until the stream sink takes them.
module stream_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = p + PW'(1'b1);
    end
  endfunction

  // Handshake qualification and head presentation (zero when empty)
  always_comb begin
    do_pop_s  = pop && (count_r != {CW{1'b0}});
    do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    valid     = (count_r != {CW{1'b0}});
    pop_data  = valid ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
    count     = count_r;
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/buffer_stream_reader.sv
// Streams a block of words out of a buffer memory read port with credit-limited prefetch.
// Optional macro BUFFER_STREAM_READER_ABORT_EN adds an abort input.
module buffer_stream_reader
  import buffer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clkb,
  input  logic              rst,
  input  logic              start,
`ifdef BUFFER_STREAM_READER_ABORT_EN
  input  logic              abort,
`endif
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = RD_LAT + 1;
  localparam int FCW   = $clog2(DEPTH + 1);

  state_t            state_r;
  logic [ADDR_W-1:0] len_r;
  logic [ADDR_W-1:0] issue_cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [RD_LAT-1:0] pipe_vld_r;
  logic [RD_LAT-1:0] pipe_last_r;
  logic [CNT_W-1:0]  inflight_r;

  logic [FCW-1:0]    fifo_count_s;
  logic [DATA_W:0]   fifo_head_s;
  logic              fifo_valid_s;
  logic              abort_s;
  logic              abort_act_s;
  logic              pop_s;
  logic              push_s;
  logic              issue_s;
  logic              last_issue_s;
  logic              credit_ok_s;
  logic [CNT_W-1:0]  occ_s;
  logic [CNT_W-1:0]  room_s;

  // Read issue decision: a read is only launched if, after this edge, in-flight plus buffered words fit the credit
  always_comb begin
`ifdef BUFFER_STREAM_READER_ABORT_EN
    abort_s = abort;
`else
    abort_s = 1'b0;
`endif
    abort_act_s  = abort_s && ((state_r == ST_READ) || (state_r == ST_DRAIN));
    pop_s        = fifo_valid_s && m_ready;
    push_s       = pipe_vld_r[RD_LAT-1] && !abort_act_s;
    occ_s        = inflight_r + CNT_W'(fifo_count_s) + CNT_W'(1'b1);
    room_s       = credit_limit(RD_LAT) + (pop_s ? CNT_W'(1'b1) : CNT_W'(1'b0));
    credit_ok_s  = (occ_s <= room_s);
    last_issue_s = (issue_cnt_r == (len_r - ADDR_W'(1'b1)));
    issue_s      = (state_r == ST_READ) && credit_ok_s && !abort_act_s;
  end

  // Transfer sequencing
  always_ff @(posedge clkb) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      len_r       <= {ADDR_W{1'b0}};
      issue_cnt_r <= {ADDR_W{1'b0}};
      addr_r      <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            len_r       <= length;
            addr_r      <= base_addr;
            issue_cnt_r <= {ADDR_W{1'b0}};
            state_r     <= (length == {ADDR_W{1'b0}}) ? ST_DONE : ST_READ;
          end
        end
        ST_READ: begin
          if (abort_act_s) begin
            state_r <= ST_DONE;
          end else if (issue_s) begin
            addr_r      <= addr_r + ADDR_W'(1'b1);
            issue_cnt_r <= issue_cnt_r + ADDR_W'(1'b1);
            if (last_issue_s) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (abort_act_s || (pop_s && fifo_head_s[DATA_W])) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Read-latency tracking: pipe_vld_r[RD_LAT-1] marks the cycle doutb holds an issued word
  always_ff @(posedge clkb) begin
    if (rst || abort_act_s) begin
      pipe_vld_r  <= {RD_LAT{1'b0}};
      pipe_last_r <= {RD_LAT{1'b0}};
      inflight_r  <= {CNT_W{1'b0}};
    end else begin
      pipe_vld_r[0]  <= issue_s;
      pipe_last_r[0] <= issue_s && last_issue_s;
      for (int j = 1; j < RD_LAT; j++) begin
        pipe_vld_r[j]  <= pipe_vld_r[j-1];
        pipe_last_r[j] <= pipe_last_r[j-1];
      end
      case ({issue_s, pipe_vld_r[RD_LAT-1]})
        2'b10:   inflight_r <= inflight_r + CNT_W'(1'b1);
        2'b01:   inflight_r <= inflight_r - CNT_W'(1'b1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  stream_skid_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1),
    .CW    (FCW)
  ) u_fifo (
    .clk       (clkb),
    .rst       (rst),
    .flush     (abort_act_s),
    .push      (push_s),
    .push_data ({pipe_last_r[RD_LAT-1], doutb}),
    .pop       (pop_s),
    .pop_data  (fifo_head_s),
    .valid     (fifo_valid_s),
    .count     (fifo_count_s)
  );

  // Port mapping from registered state
  always_comb begin
    enb     = issue_s;
    addrb   = addr_r;
    m_valid = fifo_valid_s;
    m_data  = fifo_head_s[DATA_W-1:0];
    m_last  = fifo_head_s[DATA_W];
    busy    = (state_r != ST_IDLE);
    done    = (state_r == ST_DONE);
  end

endmodule
